bt656_cap_ctrl: RTL

Capture scheduler between the BT.656 receiver/colour-converter and the SDRAM write port.
- Crops a fixed window out of the decoded video stream and pushes cropped pixels into an external write FIFO.
- Issues burst write requests to the SDRAM arbiter based on FIFO level.
- Double-buffers frames by toggling the written bank at each completed frame.

---
 rtl/bt656_pkg.sv | 25 ++
 rtl/bt656_win_cnt.sv | 51 +++++
 rtl/bt656_cap_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/bt656_pkg.sv
// Shared types and default window constants for the BT.656 capture path.
package bt656_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam int unsigned DEF_IMG_W      = 480;
    localparam int unsigned DEF_IMG_H      = 272;
    localparam int unsigned DEF_X_START    = 80;
    localparam int unsigned DEF_Y_START    = 20;
    localparam int unsigned DEF_BURST_LEN  = 256;
    localparam int unsigned DEF_FIFO_DEPTH = 512;
    localparam int unsigned DEF_ADDR_W     = 22;

endpackage

// File: rtl/bt656_win_cnt.sv
// Column counter for the active video line plus crop-window membership test.
// in_win is combinational: it qualifies the pixel strobe presented this cycle,
// using the column index that pixel occupies (count before its own increment).
module bt656_win_cnt
    import bt656_pkg::*;
#(
    parameter int unsigned IMG_W   = DEF_IMG_W,
    parameter int unsigned IMG_H   = DEF_IMG_H,
    parameter int unsigned X_START = DEF_X_START,
    parameter int unsigned Y_START = DEF_Y_START
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vid_v,
    input  logic       vid_h,
    input  logic [8:0] vid_line,
    input  logic       pix_vld,
    output logic       in_win
);
    localparam int unsigned COL_W = 12;
    localparam logic [COL_W-1:0] COL_MAX = '1;
    localparam logic [COL_W-1:0] X_LO    = COL_W'(X_START);
    localparam logic [COL_W-1:0] X_HI    = COL_W'(X_START + IMG_W);
    localparam logic [8:0]       Y_LO    = 9'(Y_START);
    localparam logic [8:0]       Y_HI    = 9'(Y_START + IMG_H);

    logic [COL_W-1:0] col_q, col_d;

    // Next column count and window decision for the current pixel strobe.
    always_comb begin
        col_d = col_q;
        if (vid_h) begin
            col_d = '0;
        end else if (pix_vld && !vid_v && (col_q != COL_MAX)) begin
            col_d = col_q + COL_W'(1);
        end
        in_win = pix_vld && !vid_h && !vid_v &&
                 (col_q >= X_LO) && (col_q < X_HI) &&
                 (vid_line >= Y_LO) && (vid_line < Y_HI);
    end

    // Column counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/bt656_cap_ctrl.sv
// Capture scheduler: crops the decoded stream into the write FIFO, issues
// SDRAM burst requests from the FIFO level and double-buffers frames.
// Optional build macro BT656_FIELD_SKIP_EN: capture only every other field.
module bt656_cap_ctrl
    import bt656_pkg::*;
#(
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned X_START    = DEF_X_START,
    parameter int unsigned Y_START    = DEF_Y_START,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              vid_v,
    input  logic              vid_h,
    input  logic [8:0]        vid_line,
    input  logic              pix_vld,
    input  logic [15:0]       pix_data,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_wr_data,
    input  logic [9:0]        fifo_level,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_len,
    input  logic              wr_ack,
    input  logic              wr_done,
    output logic              bank_wr,
    output logic              frame_done,
    output logic              ovf
);
    localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(IMG_W * IMG_H);
    localparam logic [9:0]        LVL_BURST   = 10'(BURST_LEN);
    localparam logic [9:0]        LVL_FULL    = 10'(FIFO_DEPTH - 1);
    localparam logic [8:0]        LINE_END    = 9'(Y_START + IMG_H);

    cap_state_e        state_q, state_d;
    logic              vid_v_q, vid_v_d;
    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic              bank_q, bank_d;
    logic              ovf_q, ovf_d;
    logic              abort_q, abort_d;
    logic              busy_q, busy_d;
    logic              wr_req_q, wr_req_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [8:0]        wr_len_q, wr_len_d;
    logic              push_q, push_d;
    rgb565_t           push_data_q, push_data_d;
    logic              frame_done_q, frame_done_d;
`ifdef BT656_FIELD_SKIP_EN
    logic              skip_q, skip_d;
`endif

    logic in_win;
    logic frame_start;
    logic vid_v_rise;
    logic start_ok;
    logic raise;

    bt656_win_cnt #(
        .IMG_W   (IMG_W),
        .IMG_H   (IMG_H),
        .X_START (X_START),
        .Y_START (Y_START)
    ) u_win_cnt (
        .clk      (clk),
        .rst      (rst),
        .vid_v    (vid_v),
        .vid_h    (vid_h),
        .vid_line (vid_line),
        .pix_vld  (pix_vld),
        .in_win   (in_win)
    );

    // Next-state logic for the capture FSM, burst handshake and frame bookkeeping.
    always_comb begin
        frame_start  = vid_v_q && !vid_v;
        vid_v_rise   = vid_v && !vid_v_q;
        state_d      = state_q;
        vid_v_d      = vid_v;
        wptr_d       = wptr_q;
        bank_d       = bank_q;
        ovf_d        = ovf_q;
        abort_d      = abort_q;
        busy_d       = busy_q;
        wr_req_d     = wr_req_q;
        wr_addr_d    = wr_addr_q;
        wr_len_d     = wr_len_q;
        push_d       = 1'b0;
        push_data_d  = push_data_q;
        frame_done_d = 1'b0;
        raise        = 1'b0;
`ifdef BT656_FIELD_SKIP_EN
        skip_d       = frame_start ? !skip_q : skip_q;
        start_ok     = cap_en && !skip_q;
`else
        start_ok     = cap_en;
`endif

        if (frame_start) begin
            ovf_d = 1'b0;
        end

        // Ack and completion are independent so both land when they coincide.
        if (wr_req_q && wr_ack) begin
            wr_req_d = 1'b0;
        end
        if (busy_q && wr_done) begin
            busy_d = 1'b0;
            wptr_d = wptr_q + ADDR_W'(wr_len_q);
        end

        case (state_q)
            IDLE: begin
                if (frame_start && start_ok) begin
                    state_d = ACTIVE;
                    wptr_d  = '0;
                    abort_d = 1'b0;
                end
            end
            ACTIVE: begin
                if (!cap_en) begin
                    state_d = FLUSH;
                    abort_d = 1'b1;
                end else begin
                    if (in_win) begin
                        if (fifo_level >= LVL_FULL) begin
                            ovf_d = 1'b1;
                        end else begin
                            push_d      = 1'b1;
                            push_data_d = rgb565_t'(pix_data);
                        end
                    end
                    if ((vid_line == LINE_END) || vid_v_rise) begin
                        state_d = FLUSH;
                    end
                end
                raise = !busy_q && (fifo_level >= LVL_BURST);
            end
            FLUSH: begin
                // A push still in flight is not yet visible in fifo_level.
                if (!busy_q) begin
                    if (fifo_level != '0) begin
                        raise = 1'b1;
                    end else if (!push_q) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (!ovf_q && !abort_q) begin
                    bank_d = !bank_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (raise) begin
            busy_d    = 1'b1;
            wr_req_d  = 1'b1;
            wr_len_d  = (fifo_level >= LVL_BURST) ? 9'(BURST_LEN) : fifo_level[8:0];
            wr_addr_d = (bank_q ? FRAME_WORDS : '0) + wptr_q;
        end
    end

    // State and registered-output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vid_v_q      <= 1'b0;
            wptr_q       <= '0;
            bank_q       <= 1'b0;
            ovf_q        <= 1'b0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            push_q       <= 1'b0;
            push_data_q  <= '0;
            frame_done_q <= 1'b0;
`ifdef BT656_FIELD_SKIP_EN
            skip_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vid_v_q      <= vid_v_d;
            wptr_q       <= wptr_d;
            bank_q       <= bank_d;
            ovf_q        <= ovf_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            wr_req_q     <= wr_req_d;
            wr_addr_q    <= wr_addr_d;
            wr_len_q     <= wr_len_d;
            push_q       <= push_d;
            push_data_q  <= push_data_d;
            frame_done_q <= frame_done_d;
`ifdef BT656_FIELD_SKIP_EN
            skip_q       <= skip_d;
`endif
        end
    end

    assign fifo_wr_en   = push_q;
    assign fifo_wr_data = push_data_q;
    assign wr_req       = wr_req_q;
    assign wr_addr      = wr_addr_q;
    assign wr_len       = wr_len_q;
    assign bank_wr      = bank_q;
    assign frame_done   = frame_done_q;
    assign ovf          = ovf_q;

endmodule
